// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry, output
// stage state encoding and Gray/binary pointer conversion helpers.
package fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int FIFO_PW    = FIFO_AW + 1;

    // Widest pointer the helpers handle; narrower pointers are zero-extended.
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_e;

    // Mask keeping only the low 'width' bits of a helper result.
    function automatic logic [GRAY_MAX_W-1:0] width_mask(input int width);
        logic [GRAY_MAX_W-1:0] mask;
        mask = {GRAY_MAX_W{1'b0}};
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

    // Binary to Gray: each Gray bit is the XOR of neighbouring binary bits.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] bin,
        input int                    width
    );
        logic [GRAY_MAX_W-1:0] b;
        b = bin & width_mask(width);
        return b ^ {1'b0, b[GRAY_MAX_W-1:1]};
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Bits above 'width' are cleared first so they cannot pollute the prefix XOR.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] gray,
        input int                    width
    );
        logic [GRAY_MAX_W-1:0] g;
        logic [GRAY_MAX_W-1:0] b;
        g = gray & width_mask(width);
        b = {GRAY_MAX_W{1'b0}};
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus. The first stage
// samples the asynchronous input directly with no logic in front of it.
module sync_2ff #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] q1_r;
    logic [width-1:0] q2_r;

    // Two back-to-back capture stages to let metastability resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_r <= {width{1'b0}};
            q2_r <= {width{1'b0}};
        end else begin
            q1_r <= d;
            q2_r <= q1_r;
        end
    end

    assign q = q2_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO. Synchronises the write
// pointer, derives empty and occupancy, drains the RAM into a registered
// valid/ready output stage and exports its Gray read pointer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int n = FIFO_DEPTH,
    parameter int w = FIFO_AW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [w:0]   wr_ptr_gray,
    output logic [w:0]   rd_ptr_gray,
    output logic [w-1:0] rd_addr,
    input  logic [7:0]   rd_data,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         empty,
    output logic [w:0]   level
);

    // Pointer width: one extra MSB over the address distinguishes full from empty.
    localparam int PW = $clog2(n) + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wq2_s;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] rd_ptr_bin_nxt_s;
    logic [PW-1:0] rd_ptr_gray_nxt_s;
    logic          empty_s;
    logic          load_s;

    logic [PW-1:0] rd_ptr_bin_r;
    logic [PW-1:0] rd_ptr_gray_r;
    logic [7:0]    out_data_r;
    logic          out_valid_r;
    rd_state_e     state_r;

    sync_2ff #(
        .width (PW)
    ) u_wr_ptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wr_ptr_gray),
        .q     (wq2_s)
    );

    assign wr_bin_s = PW'(gray2bin({{(GRAY_MAX_W-PW){1'b0}}, wq2_s}, PW));

    // Next pointer in both encodings; the Gray form is registered so only one
    // bit ever toggles on the bus seen by the write domain.
    assign rd_ptr_bin_nxt_s  = rd_ptr_bin_r + PTR_ONE;
    assign rd_ptr_gray_nxt_s = PW'(bin2gray({{(GRAY_MAX_W-PW){1'b0}}, rd_ptr_bin_nxt_s}, PW));

    // Equal Gray pointers mean every written word has been pulled out of the RAM.
    assign empty_s = (rd_ptr_gray_r == wq2_s);

    // Pull a new word when one is available and the output register is free
    // or being emptied by the consumer this cycle.
    assign load_s = !empty_s && (!out_valid_r || out_ready);

    // Output stage FSM with pointer advance; a held word stays frozen until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RD_IDLE;
            out_valid_r   <= 1'b0;
            out_data_r    <= 8'h00;
            rd_ptr_bin_r  <= {PW{1'b0}};
            rd_ptr_gray_r <= {PW{1'b0}};
        end else begin
            case (state_r)
                RD_IDLE: begin
                    if (load_s) begin
                        state_r       <= RD_HOLD;
                        out_valid_r   <= 1'b1;
                        out_data_r    <= rd_data;
                        rd_ptr_bin_r  <= rd_ptr_bin_nxt_s;
                        rd_ptr_gray_r <= rd_ptr_gray_nxt_s;
                    end else begin
                        state_r     <= RD_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                RD_HOLD: begin
                    if (load_s) begin
                        state_r       <= RD_HOLD;
                        out_valid_r   <= 1'b1;
                        out_data_r    <= rd_data;
                        rd_ptr_bin_r  <= rd_ptr_bin_nxt_s;
                        rd_ptr_gray_r <= rd_ptr_gray_nxt_s;
                    end else if (out_ready) begin
                        state_r     <= RD_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= RD_HOLD;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= RD_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ptr_gray = rd_ptr_gray_r;
    assign rd_addr     = rd_ptr_bin_r[w-1:0];
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign empty       = empty_s;
    assign level       = wr_bin_s - rd_ptr_bin_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a behavioural RAM answers rd_addr and the
// bench plays the write side by stepping its own Gray write pointer.
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       empty;
    logic [4:0] level;

    logic [7:0] ram [16];
    logic [4:0] wr_bin;
    int checks;
    int errors;

    assign rd_data = ram[rd_addr];

    fifo_rd_ctrl #(.n(16), .w(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .empty       (empty),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] g5(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        ram[wr_bin[3:0]] = d;
        wr_bin = wr_bin + 5'd1;
        wr_ptr_gray = g5(wr_bin);
        step(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_bin = 5'd0;
        wr_ptr_gray = 5'd0;
        out_ready = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    logic [7:0] sb [$];
    logic [7:0] exp_w;
    logic [7:0] vv;
    logic [4:0] prev_g;
    int rcv;

    task automatic sample_wrap();
        if (out_valid) begin
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
            end else begin
                exp_w = 8'hxx;
            end
            chk("wrap_data", {24'd0, out_data}, {24'd0, exp_w});
            rcv++;
        end
        chk("wrap_gray_step", {31'd0, ($countones(rd_ptr_gray ^ prev_g) <= 1)}, 32'd1);
        chk("wrap_gray_ptr", {27'd0, rd_ptr_gray}, {27'd0, g5(5'd16 + 5'(rcv))});
        prev_g = rd_ptr_gray;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        wr_bin = 5'd0;
        wr_ptr_gray = 5'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;

        // Power-up reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_gray", {27'd0, rd_ptr_gray}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        step(3);
        rst_n = 1'b1;
        step(1);

        // Single word: visible at the output three edges after the pointer step.
        push(8'hA5);
        step(1);
        chk("single_valid_early", {31'd0, out_valid}, 32'd0);
        chk("single_level_1", {27'd0, level}, 32'd1);
        chk("single_empty_0", {31'd0, empty}, 32'd0);
        step(1);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data", {24'd0, out_data}, 32'h0000_00A5);
        chk("single_gray", {27'd0, rd_ptr_gray}, 32'd1);
        chk("single_empty_1", {31'd0, empty}, 32'd1);
        chk("single_level_0", {27'd0, level}, 32'd0);
        out_ready = 1'b1;
        step(1);
        chk("single_accept_valid", {31'd0, out_valid}, 32'd0);
        chk("single_accept_data", {24'd0, out_data}, 32'h0000_00A5);
        chk("single_accept_gray", {27'd0, rd_ptr_gray}, 32'd1);
        out_ready = 1'b0;

        // Reset mid-traffic: state cleared asynchronously, before the next edge.
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        chk("mid_valid_before", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        wr_bin = 5'd0;
        wr_ptr_gray = 5'd0;
        #2;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_level", {27'd0, level}, 32'd0);
        chk("mid_rst_gray", {27'd0, rd_ptr_gray}, 32'd0);
        chk("mid_rst_addr", {28'd0, rd_addr}, 32'd0);
        step(3);
        chk("mid_rst_hold_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Backpressure: first word held while the consumer stalls.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {24'd0, out_data}, 32'h0000_0011);
            chk("bp_level", {27'd0, level}, 32'd3);
            chk("bp_addr", {28'd0, rd_addr}, 32'd1);
            step(1);
        end
        out_ready = 1'b1;
        step(1);
        chk("bp_data_22", {24'd0, out_data}, 32'h0000_0022);
        step(1);
        chk("bp_data_33", {24'd0, out_data}, 32'h0000_0033);
        step(1);
        chk("bp_data_44", {24'd0, out_data}, 32'h0000_0044);
        chk("bp_valid_44", {31'd0, out_valid}, 32'd1);
        step(1);
        chk("bp_valid_end", {31'd0, out_valid}, 32'd0);

        // Full depth: pointer jumps to 16, then all 16 words drain back to back.
        do_reset();
        for (int i = 0; i < 16; i++) ram[i] = 8'h70 + 8'(i);
        wr_bin = 5'd16;
        wr_ptr_gray = 5'b11000;
        step(2);
        chk("full_level", {27'd0, level}, 32'd16);
        chk("full_empty", {31'd0, empty}, 32'd0);
        chk("full_valid_early", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step(1);
        for (int i = 0; i < 16; i++) begin
            chk("full_valid", {31'd0, out_valid}, 32'd1);
            chk("full_data", {24'd0, out_data}, 32'h70 + 32'(i));
            step(1);
        end
        chk("full_valid_end", {31'd0, out_valid}, 32'd0);
        chk("full_empty_end", {31'd0, empty}, 32'd1);
        chk("full_gray_end", {27'd0, rd_ptr_gray}, 32'b11000);

        // Wrap-around: 40 words in bursts of 5, pointer passes 31 -> 0.
        prev_g = g5(5'd16);
        rcv = 0;
        vv = 8'h80;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 5; k++) begin
                sample_wrap();
                sb.push_back(vv);
                push(vv);
                vv = vv + 8'd1;
            end
            repeat (3) begin
                sample_wrap();
                step(1);
            end
        end
        repeat (8) begin
            sample_wrap();
            step(1);
        end
        sample_wrap();
        chk("wrap_count", 32'(rcv), 32'd40);
        chk("wrap_leftover", 32'(sb.size()), 32'd0);
        chk("wrap_final_gray", {27'd0, rd_ptr_gray}, {27'd0, g5(5'd24)});

        // Accept while empty: output drops and the pointer stays put.
        out_ready = 1'b0;
        push(8'h5A);
        step(2);
        chk("ae_valid", {31'd0, out_valid}, 32'd1);
        chk("ae_data", {24'd0, out_data}, 32'h0000_005A);
        chk("ae_gray", {27'd0, rd_ptr_gray}, {27'd0, g5(5'd25)});
        step(1);
        chk("ae_hold_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step(1);
        chk("ae_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("ae_drop_gray", {27'd0, rd_ptr_gray}, {27'd0, g5(5'd25)});
        chk("ae_drop_addr", {28'd0, rd_addr}, 32'd9);
        chk("ae_drop_empty", {31'd0, empty}, 32'd1);
        chk("ae_drop_data", {24'd0, out_data}, 32'h0000_005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
